dmem_ctrl: RTL
==============

# dmem_ctrl

Data-memory access controller for the M stage. Takes one load/store request per instruction from the execute stage, checks alignment, and runs the valid/ready request handshake to data memory. It waits for the memory response, then returns lane-extracted and sign- or zero-extended load data. It stalls the pipeline for as long as an access is outstanding.

## Interface
- N_BITS, 32, data/address width; only 32 is supported (4 byte lanes).
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_val  in  1  execute stage presents an access; held until `stall` is low.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  N_BITS  byte address.
- req_wdata  in  N_BITS  store data, right-justified.
- stall  out  1  pipeline hold request.
- misaligned  out  1  one-cycle pulse on a rejected access.
- mem_req_val  out  1  request valid to memory.
- mem_req_rdy  in  1  memory accepts the request.
- mem_req_wr  out  1  store when high.
- mem_req_addr  out  N_BITS  word address ({req_addr[31:2], 2'b00}).
- mem_req_wdata  out  N_BITS  lane-replicated store data.
- mem_req_wstrb  out  4  byte enables; 0000 for loads.
- mem_rsp_val  in  1  memory response (load data or store ack).
- mem_rsp_data  in  N_BITS  raw word read from memory.
- ld_data  out  N_BITS  formatted load result.
- ld_data_val  out  1  `ld_data` valid (loads only).

## Operation
- States: IDLE, REQ, WAIT, DONE.
- Reset: state = IDLE. All registered outputs are 0: `mem_req_val`, `mem_req_wr`, `mem_req_addr`, `mem_req_wdata`, `mem_req_wstrb`, `ld_data`, `ld_data_val`, `misaligned`. Captured request fields are cleared.
- Alignment rules:
  - half requires addr[0] = 0; word requires addr[1:0] = 0.
  - size 11 is always rejected.
- IDLE with `req_val` and an aligned access:
  - capture wr, size, unsigned, addr[1:0], word address and formatted store data;
  - go to REQ.
- IDLE with `req_val` and a misaligned access:
  - pulse `misaligned` in the next cycle; stay in IDLE;
  - no memory request, no stall.
- REQ:
  - `mem_req_val` = 1; address, data, strobe and wr are held stable;
  - on `mem_req_rdy` = 1, go to WAIT.
- WAIT: on `mem_rsp_val`, register the formatted load data into `ld_data` (loads only), then go to DONE.
- DONE:
  - `ld_data_val` = 1 for loads (0 for stores);
  - `req_val` is ignored here, because it is the same instruction being released;
  - go to IDLE unconditionally.
- `mem_rsp_val` in IDLE, REQ or DONE is ignored.
- Store formatting:
  - byte: wdata = {4{wdata[7:0]}}, wstrb = 0001 << addr[1:0];
  - half: wdata = {2{wdata[15:0]}}, wstrb = 0011 << {addr[1], 1'b0};
  - word: wdata unchanged, wstrb = 1111.
- Load formatting:
  - shifted = rsp_data >> (8·addr[1:0]);
  - byte: extend shifted[7:0]; half: extend shifted[15:0]; word: rsp_data.
  - Extension is sign or zero per the captured `req_unsigned`.
- `ld_data` holds its value after DONE until the next load completes.

## Timing
- `stall` is combinational: 1 in REQ and WAIT, and in IDLE when `req_val` is high and the access is aligned. It is 0 in DONE.
- Minimum load with `mem_req_rdy` = 1 and response one cycle after acceptance:
  - c0 IDLE accept;
  - c1 REQ handshake;
  - c2 WAIT response;
  - c3 DONE with `ld_data_val` = 1.
  - `stall` is high c0–c2, low c3.
- Back-to-back: a new request is accepted in the IDLE cycle following DONE. Throughput is one access per 4 cycles at best.
- Backpressure: each cycle `mem_req_rdy` stays low extends REQ by one cycle; outputs stay stable.
- Response latency is unbounded; WAIT extends indefinitely.
- Reset mid-operation returns to IDLE the next edge and drops `mem_req_val`. Memory shares this reset, so no stale response arrives afterwards.

## Test plan
- Aligned word load: addr 0x100, rdy = 1, rsp 0xDEADBEEF next cycle -> `mem_req_addr` = 0x100, wstrb = 0000, `stall` high 3 cycles, then `ld_data` = 0xDEADBEEF with `ld_data_val` for 1 cycle.
- Signed byte load at 0x103, rsp 0x80FF_0000 -> `ld_data` = 0xFFFF_FF80. The same access as unsigned -> 0x0000_0080. Half at 0x102 signed -> 0xFFFF_80FF.
- Byte store 0x...AB at 0x101 -> wdata = 0xABABABAB, wstrb = 0010, `mem_req_wr` = 1. Store completes on ack, with `ld_data_val` never asserted.
- Word at 0x102 and any size 11 -> `misaligned` 1-cycle pulse, `mem_req_val` never set, `stall` stays 0.
- `mem_req_rdy` low for 5 cycles -> REQ outputs stable throughout, `stall` high throughout. A spurious `mem_rsp_val` during REQ is ignored.
- Assert `rst` during WAIT -> next cycle IDLE, all outputs 0, `stall` 0. A following load completes normally.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: M-stage load/store controller. Checks alignment, runs the
// valid/ready request to data memory, waits for the response and formats
// load data. Ports: clk/rst, req_* from execute, stall/misaligned to the
// pipeline, mem_req_*/mem_rsp_* to data memory, ld_data/ld_data_val out.
module dmem_ctrl #(
  parameter int N_BITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_val,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [N_BITS-1:0] req_addr,
  input  logic [N_BITS-1:0] req_wdata,
  output logic              stall,
  output logic              misaligned,
  output logic              mem_req_val,
  input  logic              mem_req_rdy,
  output logic              mem_req_wr,
  output logic [N_BITS-1:0] mem_req_addr,
  output logic [N_BITS-1:0] mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_rsp_val,
  input  logic [N_BITS-1:0] mem_rsp_data,
  output logic [N_BITS-1:0] ld_data,
  output logic              ld_data_val
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;

  logic       cap_wr;
  logic [1:0] cap_size;
  logic       cap_uns;
  logic [1:0] cap_off;

  logic              aligned;
  logic [N_BITS-1:0] st_data;
  logic [3:0]        st_strb;
  logic [N_BITS-1:0] shifted;
  logic [N_BITS-1:0] ld_fmt;
  logic              sx_b;
  logic              sx_h;

  always_comb begin
    aligned = 1'b0;
    unique case (req_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~req_addr[0];
      2'b10:   aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Store data is replicated across lanes; the strobe picks the lane.
  always_comb begin
    st_data = req_wdata;
    st_strb = 4'b1111;
    unique case (req_size)
      2'b00: begin
        st_data = {4{req_wdata[7:0]}};
        st_strb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_data = {2{req_wdata[15:0]}};
        st_strb = 4'b0011 << {req_addr[1], 1'b0};
      end
      default: begin
        st_data = req_wdata;
        st_strb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    shifted = mem_rsp_data >> {cap_off, 3'b000};
    sx_b    = ~cap_uns & shifted[7];
    sx_h    = ~cap_uns & shifted[15];
    ld_fmt  = mem_rsp_data;
    unique case (cap_size)
      2'b00:   ld_fmt = {{(N_BITS-8){sx_b}}, shifted[7:0]};
      2'b01:   ld_fmt = {{(N_BITS-16){sx_h}}, shifted[15:0]};
      default: ld_fmt = mem_rsp_data;
    endcase
  end

  // DONE drops stall so the held instruction is released.
  always_comb begin
    stall = 1'b0;
    unique case (state)
      IDLE:    stall = req_val & aligned;
      REQ:     stall = 1'b1;
      WAIT:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cap_wr        <= 1'b0;
      cap_size      <= 2'b00;
      cap_uns       <= 1'b0;
      cap_off       <= 2'b00;
      mem_req_val   <= 1'b0;
      mem_req_wr    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= 4'b0000;
      ld_data       <= '0;
      ld_data_val   <= 1'b0;
      misaligned    <= 1'b0;
    end else begin
      misaligned  <= 1'b0;
      ld_data_val <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_val && aligned) begin
            cap_wr        <= req_wr;
            cap_size      <= req_size;
            cap_uns       <= req_unsigned;
            cap_off       <= req_addr[1:0];
            mem_req_val   <= 1'b1;
            mem_req_wr    <= req_wr;
            mem_req_addr  <= {req_addr[N_BITS-1:2], 2'b00};
            mem_req_wdata <= st_data;
            mem_req_wstrb <= req_wr ? st_strb : 4'b0000;
            state         <= REQ;
          end else if (req_val) begin
            misaligned <= 1'b1;
          end
        end
        REQ: begin
          if (mem_req_rdy) begin
            mem_req_val <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_val) begin
            if (!cap_wr) begin
              ld_data <= ld_fmt;
            end
            ld_data_val <= ~cap_wr;
            state       <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
